// File: rtl/control_pkg.sv
// Shared definitions for the control sequencer: opcodes, state encoding, IR field positions.
// Optional build macro MULDIV_EN enables the mul/div opcodes (otherwise they decode as illegal).
package control_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT,
        ST_FAULT
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MULDIV,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    // Bus/register control strobes, one bit per datapath action.
    typedef struct packed {
        logic pc_out;
        logic mar_enable;
        logic pc_increment;
        logic pc_enable;
        logic read;
        logic mdr_enable;
        logic mdr_out;
        logic ir_enable;
        logic y_enable;
        logic z_enable;
        logic zlo_out;
        logic zhi_out;
        logic lo_enable;
        logic hi_enable;
    } ctrl_t;

    function automatic op_class_e classify(input logic [4:0] op);
        op_class_e cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL, OP_NEG, OP_NOT: cls = CLS_ALU;
`ifdef MULDIV_EN
            OP_MUL, OP_DIV:                          cls = CLS_MULDIV;
`endif
            OP_HALT:                                 cls = CLS_HALT;
            default:                                 cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_sequencer_select_encode.sv
// Register select encoder: 4-bit register index plus enable to a 16-bit one-hot strobe.
module select_encode (
    input  logic [3:0]  idx_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2), decode, execute (T3-T6), with HALT/FAULT traps.
// Build macro MULDIV_EN adds the two-result mul/div sequence through T6.
module control_sequencer
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] ir_in,
    output logic        pc_out,
    output logic        mar_enable,
    output logic        pc_increment,
    output logic        pc_enable,
    output logic        read,
    output logic        mdr_enable,
    output logic        mdr_out,
    output logic        ir_enable,
    output logic        y_enable,
    output logic        z_enable,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        lo_enable,
    output logic        hi_enable,
    output logic [4:0]  op_code,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic        run,
    output logic        illegal
);

    localparam int SEL_RA = 0;
    localparam int SEL_RB = 1;
    localparam int SEL_RC = 2;

    state_e state_q, state_d;
    logic   stop_q,  stop_d;

    logic [4:0]       opc;
    op_class_e        cls;
    logic             neg_not;
    logic             is_md;
    logic             in_instr;
    logic             stop_seen;
    logic             ir_unused;

    logic [2:0][3:0]  sel_idx;
    logic [2:0]       sel_en;
    logic [2:0][15:0] sel_oh;
    ctrl_t            ctrl;
    logic [4:0]       op_code_c;

    assign opc       = ir_in[OPC_MSB:OPC_LSB];
    assign cls       = classify(opc);
    assign neg_not   = (opc == OP_NEG) || (opc == OP_NOT);
    assign is_md     = (cls == CLS_MULDIV);
    assign in_instr  = (state_q inside {ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6});
    assign stop_seen = stop_q | stop;
    assign ir_unused = ^ir_in[14:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_T0;
            ST_T0:    state_d = ST_T1;
            ST_T1:    state_d = ST_T2;
            ST_T2: begin
                case (cls)
                    CLS_ALU, CLS_MULDIV: state_d = ST_T3;
                    CLS_HALT:            state_d = ST_HALT;
                    default:             state_d = ST_FAULT;
                endcase
            end
            ST_T3:    state_d = ST_T4;
            ST_T4:    state_d = ST_T5;
            ST_T5: begin
                if (is_md)          state_d = ST_T6;
                else if (stop_seen) state_d = ST_IDLE;
                else                state_d = ST_T0;
            end
            ST_T6:    state_d = stop_seen ? ST_IDLE : ST_T0;
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        // Sticky stop request: accumulates across the instruction, dropped on return to IDLE.
        stop_d = stop_q;
        if (in_instr) stop_d = stop_seen;
        if (state_d == ST_IDLE) stop_d = 1'b0;
    end

    always_comb begin
        ctrl      = '0;
        sel_en    = '0;
        op_code_c = '0;
        case (state_q)
            ST_T0: begin
                ctrl.pc_out       = 1'b1;
                ctrl.mar_enable   = 1'b1;
                ctrl.pc_increment = 1'b1;
                ctrl.z_enable     = 1'b1;
            end
            ST_T1: begin
                ctrl.zlo_out    = 1'b1;
                ctrl.pc_enable  = 1'b1;
                ctrl.read       = 1'b1;
                ctrl.mdr_enable = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out   = 1'b1;
                ctrl.ir_enable = 1'b1;
            end
            ST_T3: begin
                sel_en[SEL_RB] = 1'b1;
                ctrl.y_enable  = 1'b1;
            end
            ST_T4: begin
                // Unary ops take their single operand from Rb.
                if (neg_not) sel_en[SEL_RB] = 1'b1;
                else         sel_en[SEL_RC] = 1'b1;
                op_code_c     = opc;
                ctrl.z_enable = 1'b1;
            end
            ST_T5: begin
                ctrl.zlo_out = 1'b1;
                if (is_md) begin
`ifdef MULDIV_EN
                    ctrl.lo_enable = 1'b1;
`endif
                end else begin
                    sel_en[SEL_RA] = 1'b1;
                end
            end
            ST_T6: begin
                ctrl.zhi_out = 1'b1;
`ifdef MULDIV_EN
                ctrl.hi_enable = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign sel_idx[SEL_RA] = ir_in[RA_MSB:RA_LSB];
    assign sel_idx[SEL_RB] = ir_in[RB_MSB:RB_LSB];
    assign sel_idx[SEL_RC] = ir_in[RC_MSB:RC_LSB];

    for (genvar g = 0; g < 3; g++) begin : g_sel
        select_encode u_sel (
            .idx_i    (sel_idx[g]),
            .en_i     (sel_en[g]),
            .onehot_o (sel_oh[g])
        );
    end

    assign reg_in  = sel_oh[SEL_RA];
    assign reg_out = sel_oh[SEL_RB] | sel_oh[SEL_RC];
    assign op_code = op_code_c;

    assign pc_out       = ctrl.pc_out;
    assign mar_enable   = ctrl.mar_enable;
    assign pc_increment = ctrl.pc_increment;
    assign pc_enable    = ctrl.pc_enable;
    assign read         = ctrl.read;
    assign mdr_enable   = ctrl.mdr_enable;
    assign mdr_out      = ctrl.mdr_out;
    assign ir_enable    = ctrl.ir_enable;
    assign y_enable     = ctrl.y_enable;
    assign z_enable     = ctrl.z_enable;
    assign zlo_out      = ctrl.zlo_out;
    assign zhi_out      = ctrl.zhi_out;
    assign lo_enable    = ctrl.lo_enable;
    assign hi_enable    = ctrl.hi_enable;

    assign run     = in_instr;
    assign illegal = (state_q == ST_FAULT);

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against an instruction-step reference model.
module tb_control_sequencer;

    typedef struct packed {
        logic pc_out, mar_enable, pc_increment, pc_enable, read, mdr_enable, mdr_out;
        logic ir_enable, y_enable, z_enable, zlo_out, zhi_out, lo_enable, hi_enable;
        logic [4:0]  op_code;
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic run, illegal;
    } ow_t;

    logic clk = 1'b0, clr = 1'b1, start = 1'b0, stop = 1'b0;
    logic [31:0] ir = '0;
    logic pc_out, mar_enable, pc_increment, pc_enable, read, mdr_enable, mdr_out;
    logic ir_enable, y_enable, z_enable, zlo_out, zhi_out, lo_enable, hi_enable;
    logic [4:0] op_code;
    logic [15:0] reg_in, reg_out;
    logic run, illegal;
    ow_t obs;

    int checks = 0, errors = 0;

    // Model: mode 0 idle, 1 executing (step = T index), 2 halted, 3 faulted.
    int m_mode = 0, m_step = 0;
    bit m_stop = 0;

    control_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .stop(stop), .ir_in(ir),
        .pc_out(pc_out), .mar_enable(mar_enable), .pc_increment(pc_increment),
        .pc_enable(pc_enable), .read(read), .mdr_enable(mdr_enable), .mdr_out(mdr_out),
        .ir_enable(ir_enable), .y_enable(y_enable), .z_enable(z_enable),
        .zlo_out(zlo_out), .zhi_out(zhi_out), .lo_enable(lo_enable), .hi_enable(hi_enable),
        .op_code(op_code), .reg_in(reg_in), .reg_out(reg_out), .run(run), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {pc_out, mar_enable, pc_increment, pc_enable, read, mdr_enable, mdr_out,
                  ir_enable, y_enable, z_enable, zlo_out, zhi_out, lo_enable, hi_enable,
                  op_code, reg_in, reg_out, run, illegal};

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic bit is_alu(input logic [4:0] op);
        return (op >= 5'd3 && op <= 5'd11) || op == 5'd17 || op == 5'd18;
    endfunction

    function automatic bit is_md(input logic [4:0] op);
`ifdef MULDIV_EN
        return op == 5'd15 || op == 5'd16;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int instr_len(input logic [4:0] op);
        return is_md(op) ? 7 : 6;
    endfunction

    task automatic model_edge();
        logic [4:0] op = ir[31:27];
        bit sflag = m_stop | stop;
        if (clr) begin
            m_mode = 0; m_stop = 0;
        end else if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_step = 0; end
        end else if (m_mode == 1) begin
            if (m_step == 2 && op == 5'd27)                  m_mode = 2;
            else if (m_step == 2 && !is_alu(op) && !is_md(op)) m_mode = 3;
            else if (m_step == instr_len(op) - 1) begin
                m_step = 0;
                if (sflag) m_mode = 0;
                sflag = 0;
            end else m_step++;
            m_stop = sflag;
        end
    endtask

    function automatic ow_t exp_word();
        ow_t w = '0;
        logic [4:0] op = ir[31:27];
        logic [3:0] ra = ir[26:23], rb = ir[22:19], rc = ir[18:15];
        if (m_mode == 3) w.illegal = 1'b1;
        if (m_mode == 1) begin
            w.run = 1'b1;
            case (m_step)
                0: begin w.pc_out = 1; w.mar_enable = 1; w.pc_increment = 1; w.z_enable = 1; end
                1: begin w.zlo_out = 1; w.pc_enable = 1; w.read = 1; w.mdr_enable = 1; end
                2: begin w.mdr_out = 1; w.ir_enable = 1; end
                3: begin w.reg_out = 16'd1 << rb; w.y_enable = 1; end
                4: begin
                    w.reg_out  = 16'd1 << ((op == 5'd17 || op == 5'd18) ? rb : rc);
                    w.op_code  = op;
                    w.z_enable = 1;
                end
                5: begin
                    w.zlo_out = 1;
                    if (is_md(op)) w.lo_enable = 1;
                    else           w.reg_in = 16'd1 << ra;
                end
                default: begin w.zhi_out = 1; w.hi_enable = 1; end
            endcase
        end
        return w;
    endfunction

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk(tag, 64'(obs), 64'(exp_word()));
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] op;
        int k = $urandom_range(0, 19);
        if (k <= 12) begin
            op = (k <= 8) ? 5'(k + 3) : (k <= 10 ? 5'(k + 8) : (k == 11 ? 5'd15 : 5'd16));
        end else if (k == 13) begin
            op = 5'd27;
        end else if (k == 14) begin
            do op = 5'($urandom_range(0, 31));
            while (is_alu(op) || op == 5'd15 || op == 5'd16 || op == 5'd27);
        end else begin
            op = 5'($urandom_range(3, 11));
        end
        return {op, 27'($urandom)};
    endfunction

    initial begin
        int stuck = 0;
        // Reset state
        clr = 1; start = 1;
        cyc("reset0"); cyc("reset1");
        chk("reset_zero", 64'(obs), 64'd0);
        clr = 0; start = 0;

        // shr R4,R3,R7
        ir = 32'h4A1B8000; start = 1;
        cyc("shr_t0"); start = 0;
        cyc("shr_t1"); cyc("shr_t2");
        cyc("shr_t3"); chk("shr_t3_regout", 64'(reg_out), 64'h0008);
        cyc("shr_t4"); chk("shr_t4_regout", 64'(reg_out), 64'h0080);
        chk("shr_t4_opcode", 64'(op_code), 64'h09);
        cyc("shr_t5"); chk("shr_t5_regin", 64'(reg_in), 64'h0010);
        cyc("shr_next"); chk("shr_next_t0", 64'(pc_out), 64'd1);

        // not R2,R5 with a one-cycle stop pulse in T3
        ir = 32'h91280000;
        cyc("not_t1"); cyc("not_t2"); cyc("not_t3");
        stop = 1;
        cyc("not_t4"); stop = 0;
        chk("not_t4_regout", 64'(reg_out), 64'h0020);
        cyc("not_t5"); chk("not_t5_regin", 64'(reg_in), 64'h0004);
        cyc("not_idle"); chk("not_idle_run", 64'(run), 64'd0);

        // clr in T4, with start held to show clr wins
        ir = 32'h4A1B8000; start = 1;
        cyc("clr_t0"); start = 0;
        cyc("clr_t1"); cyc("clr_t2"); cyc("clr_t3"); cyc("clr_t4");
        clr = 1; start = 1;
        cyc("clr_idle"); chk("clr_idle_zero", 64'(obs), 64'd0);
        clr = 0; start = 0;

        // illegal opcode traps until clr
        ir = 32'h0; start = 1;
        cyc("ill_t0"); cyc("ill_t1"); cyc("ill_t2"); cyc("ill_fault");
        chk("ill_flag", 64'({illegal, run}), 64'b10);
        cyc("ill_hold0"); cyc("ill_hold1");
        chk("ill_hold_flag", 64'(illegal), 64'd1);
        clr = 1; start = 0;
        cyc("ill_clr"); clr = 0;

        // halt holds until clr
        ir = {5'b11011, 27'h0}; start = 1;
        cyc("halt_t0"); cyc("halt_t1"); cyc("halt_t2"); cyc("halt_st"); cyc("halt_hold");
        chk("halt_flags", 64'({illegal, run}), 64'b00);
        clr = 1; start = 0;
        cyc("halt_clr"); clr = 0;

        // mul R1,R3,R7
        ir = {5'b10000, 4'd1, 4'd3, 4'd7, 15'd0}; start = 1;
        cyc("md_t0"); start = 0;
        cyc("md_t1"); cyc("md_t2");
`ifdef MULDIV_EN
        cyc("md_t3"); chk("md_t3_regout", 64'(reg_out), 64'h0008);
        cyc("md_t4"); chk("md_t4_regout", 64'(reg_out), 64'h0080);
        cyc("md_t5"); chk("md_t5", 64'({zlo_out, lo_enable, reg_in}), {46'd0, 2'b11, 16'h0});
        cyc("md_t6"); chk("md_t6", 64'({zhi_out, hi_enable, reg_in}), {46'd0, 2'b11, 16'h0});
        cyc("md_next");
`else
        cyc("md_fault"); chk("md_fault_flag", 64'(illegal), 64'd1);
`endif
        clr = 1; cyc("md_clr"); clr = 0;

        // Randomized run
        for (int i = 0; i < 800; i++) begin
            clr   = 0;
            start = ($urandom_range(0, 3) != 0);
            stop  = ($urandom_range(0, 11) == 0);
            if ((m_mode >= 2 && stuck > 3) || $urandom_range(0, 99) == 0) clr = 1;
            if (m_mode == 0 || (m_mode == 1 && m_step == 0)) ir = rand_ir();
            cyc("rand");
            stuck = (m_mode >= 2) ? stuck + 1 : 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 clr  input  1  reset; synchronous, active-high.
REQ-003 start  input  1  begin fetching when IDLE.
REQ-004 stop  input  1  request return to IDLE after current instruction.
REQ-005 ir_in  input  32  IR contents: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-006 pc_out  output  1  drive PC onto bus.
REQ-007 mar_enable  output  1  load MAR from bus.
REQ-008 pc_increment  output  1  ALU computes PC+1.
REQ-009 pc_enable  output  1  load PC from bus.
REQ-010 read  output  1  MDR mux selects memory data.
REQ-011 mdr_enable  output  1  load MDR.
REQ-012 mdr_out  output  1  drive MDR onto bus.
REQ-013 ir_enable  output  1  load IR from bus.
REQ-014 y_enable  output  1  load Y from bus.
REQ-015 z_enable  output  1  load Z from ALU.
REQ-016 zlo_out  output  1  drive ZLO onto bus.
REQ-017 zhi_out  output  1  drive ZHI onto bus.
REQ-018 lo_enable  output  1  load LO from bus.
REQ-019 hi_enable  output  1  load HI from bus.
REQ-020 op_code  output  5  ALU operation.
REQ-021 reg_in  output  16  one-hot general-register load enables.
REQ-022 reg_out  output  16  one-hot general-register bus drives.
REQ-023 run  output  1  high outside IDLE, HALT and FAULT.
REQ-024 illegal  output  1  high in FAULT.

Function
REQ-025 States IDLE, T0..T6, HALT, FAULT; one clock per state; all outputs decoded from state and IR fields (Moore, glitch-free, registered state).
REQ-026 IDLE: all outputs 0; start=1 -> T0.
REQ-027 T0: pc_out, mar_enable, pc_increment, z_enable. T1: zlo_out, pc_enable, read, mdr_enable. T2: mdr_out, ir_enable.
REQ-028 After T2, decode ir_in[31:27]: ALU ops add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, neg 10001, not 10010 -> T3; mul 10000 and div 01111 -> T3; halt 11011 -> HALT; any other -> FAULT.
REQ-029 T3: reg_out = onehot(Rb), y_enable.
REQ-030 T4: reg_out = onehot(Rc), or onehot(Rb) for neg/not; op_code = ir_in[31:27]; z_enable.
REQ-031 T5: zlo_out plus reg_in = onehot(Ra); for mul/div, lo_enable instead of reg_in, then T6.
REQ-032 T6 (mul/div only): zhi_out, hi_enable.
REQ-033 End of instruction (T5 non-mul/div, T6): stop seen high during any cycle of the instruction (sticky flag) -> IDLE, else T0; flag clears on IDLE entry.
REQ-034 op_code = 0 in all states except T4; at most one *_out or reg_out bit active per cycle.
REQ-035 HALT and FAULT hold until clr; start ignored there.

Reset
REQ-036 clr=1 at any edge, including mid-instruction: next state IDLE, stop flag 0, all outputs 0; clr dominates start.

Configuration
REQ-037 MULDIV_EN defined: mul/div sequence per REQ-031/032; undefined: opcodes 10000/01111 -> FAULT, T6 absent, lo_enable/hi_enable tied 0.

Structure
REQ-038 Package control_pkg: opcode constants, state encodings, IR field bit positions.
REQ-039 Sub-module select_encode: 4-bit register index + enable -> 16-bit one-hot; three instances (Ra, Rb, Rc).

Verification
REQ-040 start, ir_in=0x4A1B8000 (shr R4,R3,R7) -> T3 reg_out=0x0008, T4 reg_out=0x0080 op_code=01001, T5 reg_in=0x0010, then T0.
REQ-041 MULDIV_EN, ir_in opcode 10000 Rb=3 Rc=7 -> T5 zlo_out+lo_enable, T6 zhi_out+hi_enable, reg_in=0 throughout.
REQ-042 ir_in=0x00000000 (ld) -> FAULT after T2, illegal=1, run=0; start ignored until clr.
REQ-043 clr asserted in T4 -> next cycle IDLE, all outputs 0, op_code=0.
REQ-044 stop pulsed one cycle in T3 of not R2,R5 (0x91280000) -> T4 reg_out=0x0020, T5 reg_in=0x0004, then IDLE.
